// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the hazard/forwarding stage.
// Stage record, forward-select codes and register-address width.
package cpu_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_RSV = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel_logic.sv
// Forward select for one EX operand.
// MEM ALU result beats WB result; x0 is never forwarded.
module fwd_sel_logic
  import cpu_ctrl_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] src_i,
  input  logic          mem_valid_i,
  input  logic          mem_regwrite_i,
  input  logic          mem_memread_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic          wb_valid_i,
  input  logic          wb_regwrite_i,
  input  logic [AW-1:0] wb_rd_i,
  output logic [1:0]    sel_o
);

  logic src_nz;
  logic mem_hit;
  logic wb_hit;

  assign src_nz  = |src_i;
  assign mem_hit = mem_valid_i & mem_regwrite_i
                 & ~mem_memread_i
                 & (mem_rd_i == src_i) & src_nz;
  assign wb_hit  = wb_valid_i & wb_regwrite_i
                 & (wb_rd_i == src_i) & src_nz;

  always_comb begin
    sel_o = FWD_RF;
    unique case (1'b1)
      mem_hit:            sel_o = FWD_MEM;
      (~mem_hit & wb_hit): sel_o = FWD_WB;
      default:            sel_o = FWD_RF;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, load-use stall and redirect flush for EX.
// Optional HAZ_PERF_CNT_EN adds stall/flush event counters.
module fwd_hazard_unit #(
  parameter int REG_AW = cpu_ctrl_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_redirect,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  import cpu_ctrl_pkg::*;

  stage_rec_t ex_q, ex_d;
  stage_rec_t mem_q, mem_d;
  stage_rec_t wb_q, wb_d;
  stage_rec_t id_rec;

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  // Unused sources and invalid slots are normalised to zero.
  always_comb begin
    id_rec          = REC_BUBBLE;
    id_rec.valid    = id_valid;
    id_rec.rd       = id_valid ? id_rd : '0;
    id_rec.regwrite = id_valid & id_regwrite;
    id_rec.memread  = id_valid & id_memread;
    id_rec.rs1      = (id_valid & id_rs1_used) ? id_rs1 : '0;
    id_rec.rs2      = (id_valid & id_rs2_used) ? id_rs2 : '0;
  end

  assign rs1_hit  = id_rs1_used & (id_rs1 == ex_q.rd);
  assign rs2_hit  = id_rs2_used & (id_rs2 == ex_q.rd);
  assign load_use = id_valid & ex_q.valid & ex_q.memread
                  & (|ex_q.rd) & (rs1_hit | rs2_hit);

  always_comb begin
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    unique case (1'b1)
      hold: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
      end
      (~hold & ex_redirect): begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      (~hold & ~ex_redirect & load_use): begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d          = REC_BUBBLE;
      wb_d.valid    = mem_q.valid;
      wb_d.rd       = mem_q.rd;
      wb_d.regwrite = mem_q.regwrite;
      mem_d         = REC_BUBBLE;
      mem_d.valid   = ex_q.valid;
      mem_d.rd      = ex_q.rd;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memread = ex_q.memread;
      ex_d          = flush_idex ? REC_BUBBLE : id_rec;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q  <= REC_BUBBLE;
      mem_q <= REC_BUBBLE;
      wb_q  <= REC_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_sel_logic #(.AW(REG_AW)) u_fwd_a (
    .src_i          (ex_q.rs1),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_memread_i  (mem_q.memread),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .sel_o          (fwd_a)
  );

  fwd_sel_logic #(.AW(REG_AW)) u_fwd_b (
    .src_i          (ex_q.rs2),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_memread_i  (mem_q.memread),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .sel_o          (fwd_b)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // A load-use masked by a redirect is not a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold && !ex_redirect && load_use)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!hold && ex_redirect)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rstn;
  logic       hold;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       ex_redirect;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall_pc;
  logic       stall_ifid;
  logic       flush_ifid;
  logic       flush_idex;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_cmp;
  int n_err;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .hold        (hold),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .ex_redirect (ex_redirect),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic id_set(input logic v,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic idle();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    hold        = 1'b0;
    ex_redirect = 1'b0;
    idle();
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  // alu: rd = rs1 op rs2 ; ld: rd = mem[rs1]
  task automatic alu(input logic [4:0] rd,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2);
    id_set(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0);
  endtask

  task automatic ld(input logic [4:0] rd, input logic [4:0] rs1);
    id_set(1'b1, rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rstn        = 1'b0;
    hold        = 1'b0;
    ex_redirect = 1'b0;
    idle();
    #12;
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("rst_stall", {30'd0, stall_pc, stall_ifid}, 32'd0);
    chk("rst_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // add x5,x1,x2 ; sub x6,x5,x3
    alu(5'd5, 5'd1, 5'd2);
    @(negedge clk);
    chk("t1_c0_stall", {31'd0, stall_pc}, 32'd0);
    step();
    alu(5'd6, 5'd5, 5'd3);
    @(negedge clk);
    chk("t1_c1_stall", {31'd0, stall_pc}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t1_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("t1_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("t1_stall", {30'd0, stall_pc, flush_idex}, 32'd0);

    // add x5 ; nop ; or x7,x4,x5
    do_reset();
    alu(5'd5, 5'd1, 5'd2);
    step();
    idle();
    step();
    alu(5'd7, 5'd4, 5'd5);
    step();
    idle();
    @(negedge clk);
    chk("t2_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("t2_fwd_b", {30'd0, fwd_b}, 32'd1);

    // MEM beats WB; x0 operand stays on RF
    do_reset();
    alu(5'd5, 5'd1, 5'd2);
    step();
    alu(5'd5, 5'd1, 5'd1);
    step();
    alu(5'd10, 5'd5, 5'd0);
    step();
    idle();
    @(negedge clk);
    chk("t3_fwd_a_mem", {30'd0, fwd_a}, 32'd2);
    chk("t3_fwd_b_x0", {30'd0, fwd_b}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("t3_rst_fwd_a", {30'd0, fwd_a}, 32'd0);

    // lw x8 ; add x9,x8,x8
    do_reset();
    ld(5'd8, 5'd2);
    step();
    alu(5'd9, 5'd8, 5'd8);
    @(negedge clk);
    chk("t4_stall_pc", {31'd0, stall_pc}, 32'd1);
    chk("t4_stall_ifid", {31'd0, stall_ifid}, 32'd1);
    chk("t4_flush_idex", {31'd0, flush_idex}, 32'd1);
    chk("t4_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    step();
    @(negedge clk);
    chk("t4_c2_stall", {30'd0, stall_pc, flush_idex}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t4_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("t4_fwd_b", {30'd0, fwd_b}, 32'd1);

    // load-use with redirect in the same cycle
    do_reset();
    ld(5'd8, 5'd2);
    step();
    alu(5'd9, 5'd8, 5'd8);
    ex_redirect = 1'b1;
    @(negedge clk);
    chk("t5_flush", {30'd0, flush_ifid, flush_idex}, 32'd3);
    chk("t5_stall", {30'd0, stall_pc, stall_ifid}, 32'd0);
    ex_redirect = 1'b0;
    #1;
    chk("t5_lu_back", {31'd0, stall_pc}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_stall", {30'd0, stall_pc, flush_idex}, 32'd0);

    // x0 producers: no forward, no stall
    do_reset();
    alu(5'd0, 5'd1, 5'd2);
    step();
    alu(5'd3, 5'd0, 5'd0);
    step();
    idle();
    @(negedge clk);
    chk("t6_fwd_x0", {30'd0, fwd_a}, 32'd0);
    do_reset();
    ld(5'd0, 5'd2);
    step();
    alu(5'd3, 5'd0, 5'd0);
    @(negedge clk);
    chk("t6_lu_x0", {30'd0, stall_pc, flush_idex}, 32'd0);

    // hold freezes records for 3 cycles
    do_reset();
    alu(5'd5, 5'd1, 5'd2);
    step();
    alu(5'd6, 5'd5, 5'd3);
    step();
    idle();
    @(negedge clk);
    chk("t7_pre_fwd_a", {30'd0, fwd_a}, 32'd2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_redirect = (i == 1);
      step();
      @(negedge clk);
      chk("t7_hold_fwd_a", {30'd0, fwd_a}, 32'd2);
      chk("t7_hold_stall", {30'd0, stall_pc, stall_ifid}, 32'd3);
      chk("t7_hold_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    end
    ex_redirect = 1'b0;
    hold        = 1'b0;
    #1;
    chk("t7_unhold_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("t7_unhold_stall", {31'd0, stall_pc}, 32'd0);
    step();
    @(negedge clk);
    chk("t7_adv_fwd_a", {30'd0, fwd_a}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
